mul_ex_lane: RTL and testbench

Two-stage pipelined integer multiply unit for the MUL lanes (INT_MUL_LANE_MASK). It consumes the per-lane EX1 instruction produced by the forwarding stage, runs EX1/EX2, and presents one result entry to the CDB/commit stage. Back-pressure from CDB arbitration stalls the lane and is reported upstream to the RS as a ready signal.

---
 rtl/mul_ex_lane_pkg.sv | 34 +++
 rtl/mul_ex_lane_pp.sv | 29 ++
 rtl/mul_ex_lane.sv | 124 ++++++++++++
 tb/tb_mul_ex_lane.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mul_ex_lane_pkg.sv
// Shared types and constants for the integer multiply lane.
package mul_ex_lane_pkg;

    localparam int XLEN    = 32;
    localparam int ROB_W   = 6;
    localparam int MUL_LAT = 2;   // EX1 issue -> CDB visible, used by RS wakeup

    localparam int RS_1 = 0;
    localparam int RS_2 = 1;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;

    typedef struct packed {
        logic             v;
        logic [ROB_W-1:0] robid;
        logic [XLEN-1:0]  data;
    } cdb_t;

    typedef struct packed {
        logic                 v;
        logic [ROB_W-1:0]     robid;
        logic [2:0]           func3;
        logic [1:0][XLEN-1:0] src;
    } info_instr_inflight_t;

    // Operand signedness for a func3: {a_signed, b_signed}.
    function automatic logic [1:0] mul_signs(input logic [2:0] f3);
        return {(f3 == MULH_F3) || (f3 == MULHSU_F3), (f3 == MULH_F3)};
    endfunction

endpackage

// File: rtl/mul_ex_lane_pp.sv
// Combinational partial-product generator for two (DATA_LEN+1)-bit signed operands.
// Each operand is split into an unsigned low half and a signed high half; the four
// cross products are returned sign-extended to DATA_LEN+2 bits.
// pp_o[0]=lo*lo, pp_o[1]=a_lo*b_hi, pp_o[2]=a_hi*b_lo, pp_o[3]=hi*hi.
module mul_pp #(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN:0]                  a_i,
    input  logic [DATA_LEN:0]                  b_i,
    output logic [3:0][DATA_LEN+1:0]           pp_o
);
    localparam int H   = DATA_LEN / 2;
    localparam int PPW = DATA_LEN + 2;

    logic [PPW-1:0] a_lo, a_hi, b_lo, b_hi;

    // Extend halves to the product width so a plain truncated multiply is exact.
    always_comb begin
        a_lo = {{(PPW-H){1'b0}}, a_i[H-1:0]};
        b_lo = {{(PPW-H){1'b0}}, b_i[H-1:0]};
        a_hi = {{(PPW-H-1){a_i[DATA_LEN]}}, a_i[DATA_LEN:H]};
        b_hi = {{(PPW-H-1){b_i[DATA_LEN]}}, b_i[DATA_LEN:H]};
        pp_o[0] = a_lo * b_lo;
        pp_o[1] = a_lo * b_hi;
        pp_o[2] = a_hi * b_lo;
        pp_o[3] = a_hi * b_hi;
    end

endmodule

// File: rtl/mul_ex_lane.sv
// Two-stage integer multiply lane: S1 holds partial products, OUT holds the CDB entry.
// Back-pressure from the CDB arbiter stalls the lane and surfaces as mul_rdy.
module mul_ex_lane
    import mul_ex_lane_pkg::*;
#(
    parameter int DATA_LEN      = XLEN,
    parameter int ROB_SIZE_CLOG = ROB_W,
    parameter bit CHK_DIV_F3    = 1'b1   // flag divide-class func3 reaching this lane
) (
    input  logic                 clk,
    input  logic                 rst,
    input  info_instr_inflight_t info_instr_ex1_i,
    input  logic                 flush,
    input  logic                 cdb_gnt,
    output cdb_t                 mul_cdb,
    output logic                 mul_rdy
);
    localparam int PPW = DATA_LEN + 2;
    localparam int PW  = 2 * DATA_LEN;   // only the low 2*DATA_LEN product bits are ever used

    // S1 stage
    logic                     s1_v_q, s1_v_d;
    logic [ROB_SIZE_CLOG-1:0] s1_robid_q, s1_robid_d;
    logic [2:0]               s1_func3_q, s1_func3_d;
    logic [3:0][PPW-1:0]      s1_pp_q, s1_pp_d, pp_ex1;

    // OUT stage
    cdb_t cdb_q, cdb_d;

    logic              out_en, s1_en;
    logic [1:0]        sgn;
    logic [DATA_LEN:0] op_a, op_b;
    logic [3:0][PW-1:0] pp_x;
    logic [PW-1:0]     prod;
    logic [DATA_LEN-1:0] res;

    assign out_en  = ~cdb_q.v | cdb_gnt;
    assign s1_en   = ~s1_v_q | out_en;
    assign mul_rdy = s1_en;
    assign mul_cdb = cdb_q;

    // EX1: extend operands to DATA_LEN+1 bits according to func3 signedness.
    always_comb begin
        sgn  = mul_signs(info_instr_ex1_i.func3);
        op_a = {sgn[1] & info_instr_ex1_i.src[RS_1][DATA_LEN-1], info_instr_ex1_i.src[RS_1]};
        op_b = {sgn[0] & info_instr_ex1_i.src[RS_2][DATA_LEN-1], info_instr_ex1_i.src[RS_2]};
    end

    mul_pp #(.DATA_LEN(DATA_LEN)) u_pp (
        .a_i  (op_a),
        .b_i  (op_b),
        .pp_o (pp_ex1)
    );

    // S1 next state: flush kills, otherwise load when the stage can advance.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_robid_d = s1_robid_q;
        s1_func3_d = s1_func3_q;
        s1_pp_d    = s1_pp_q;
        if (flush) begin
            s1_v_d = 1'b0;
        end else if (s1_en) begin
            s1_v_d     = info_instr_ex1_i.v;
            s1_robid_d = info_instr_ex1_i.robid;
            s1_func3_d = info_instr_ex1_i.func3;
            s1_pp_d    = pp_ex1;
        end
    end

    // OUT: sign-extend partial products, recombine, select low/high half.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pp_x[k] = {{(PW-PPW){s1_pp_q[k][PPW-1]}}, s1_pp_q[k]};
        end
        prod = (pp_x[3] << DATA_LEN) + ((pp_x[2] + pp_x[1]) << (DATA_LEN / 2)) + pp_x[0];
        res  = '0;
        if (!s1_func3_q[2]) begin
            res = (s1_func3_q == MUL_F3) ? prod[DATA_LEN-1:0] : prod[PW-1:DATA_LEN];
        end
    end

    // OUT next state: hold a valid entry until granted; flush clears regardless.
    always_comb begin
        cdb_d = cdb_q;
        if (flush) begin
            cdb_d.v = 1'b0;
        end else if (out_en) begin
            cdb_d.v     = s1_v_q;
            cdb_d.robid = s1_robid_q;
            cdb_d.data  = res;
        end
    end

    // Stage registers with synchronous reset discarding all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_robid_q <= '0;
            s1_func3_q <= '0;
            s1_pp_q    <= '0;
            cdb_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_robid_q <= s1_robid_d;
            s1_func3_q <= s1_func3_d;
            s1_pp_q    <= s1_pp_d;
            cdb_q      <= cdb_d;
        end
    end

    // The RS must never issue into a stalled lane; such an instruction is dropped.
    a_issue_stalled: assert property (@(posedge clk) disable iff (rst)
        !(info_instr_ex1_i.v && !mul_rdy))
        else $error("mul_ex_lane: issue while mul_rdy=0, instruction dropped");

    // Divide-class ops complete with data 0 so the ROB drains, but are flagged.
    if (CHK_DIV_F3) begin : g_div_chk
        a_div_f3: assert property (@(posedge clk) disable iff (rst)
            !(info_instr_ex1_i.v && mul_rdy && !flush && info_instr_ex1_i.func3[2]))
            else $error("mul_ex_lane: divide-class func3 issued to multiply lane");
    end

endmodule

// File: tb/tb_mul_ex_lane.sv
// Self-checking bench for mul_ex_lane: directed table, hand sequences, random traffic.
module tb_mul_ex_lane;
    import mul_ex_lane_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    info_instr_inflight_t ins;
    logic                 flush, gnt;
    cdb_t                 cdb;
    logic                 rdy;

    always #5 clk = ~clk;

    mul_ex_lane #(.DATA_LEN(32), .ROB_SIZE_CLOG(6), .CHK_DIV_F3(1'b0)) dut (
        .clk              (clk),
        .rst              (rst),
        .info_instr_ex1_i (ins),
        .flush            (flush),
        .cdb_gnt          (gnt),
        .mul_cdb          (cdb),
        .mul_rdy          (rdy)
    );

    typedef struct { int t; logic [5:0] robid; logic [31:0] data; } exp_t;
    typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;

    exp_t q[$];            // issued, not yet granted, oldest first
    vec_t tbl[10];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   chk_zero = 0;

    // Reference: 64-bit arithmetic on extended operands.
    function automatic logic [31:0] ref_mul(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint ea, eb, p;
        if (f3[2]) return 32'h0;
        ea = (f3 == MULH_F3 || f3 == MULHSU_F3) ? longint'($signed(a)) : longint'({32'b0, a});
        eb = (f3 == MULH_F3) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = ea * eb;
        return (f3 == MUL_F3) ? p[31:0] : p[63:32];
    endfunction

    // Lane is busy only when two ops are held and the head is not being granted.
    function automatic bit model_rdy(logic g);
        return !(q.size() == 2 && !g);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at the edge.
    task automatic step(logic v, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                        logic [5:0] rid, logic g, logic fl, logic [31:0] exp_data);
        bit   expv, exprdy;
        exp_t e;
        ins.v = v; ins.func3 = f3; ins.src[RS_1] = a; ins.src[RS_2] = b; ins.robid = rid;
        gnt = g; flush = fl;
        @(negedge clk);
        expv   = (q.size() > 0) && (q[0].t + 2 <= cyc);
        exprdy = model_rdy(g);
        chk("mul_rdy", 32'(rdy), 32'(exprdy));
        chk("cdb.v", 32'(cdb.v), 32'(expv));
        if (expv) begin
            chk("cdb.robid", 32'(cdb.robid), 32'(q[0].robid));
            chk("cdb.data", cdb.data, q[0].data);
        end else if (chk_zero) begin
            chk("reset robid", 32'(cdb.robid), 32'h0);
            chk("reset data", cdb.data, 32'h0);
        end
        if (fl) q.delete();
        else begin
            if (expv && g) void'(q.pop_front());
            if (v && exprdy) begin
                e.t = cyc; e.robid = rid; e.data = exp_data;
                q.push_back(e);
            end
        end
        @(posedge clk); #1; cyc++;
    endtask

    task automatic idle(logic g);
        step(1'b0, 3'b0, 32'h0, 32'h0, 6'h0, g, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic        g, fl, v;
        int          n;

        tbl[0] = '{MUL_F3,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[1] = '{MULH_F3,   32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        tbl[2] = '{MULHSU_F3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[3] = '{MULHU_F3,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        tbl[4] = '{MULHU_F3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[5] = '{MULH_F3,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        tbl[6] = '{MUL_F3,    32'h12345678, 32'h00000010, 32'h23456780};
        tbl[7] = '{3'b100,    32'h00001234, 32'h00005678, 32'h00000000};
        tbl[8] = '{MULH_F3,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
        tbl[9] = '{MULHSU_F3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        rst = 1'b1; ins = '0; gnt = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;

        // First cycle out of reset: idle, zeroed entry, ready.
        chk_zero = 1; idle(1'b0); chk_zero = 0;

        // Directed vectors, one per cycle with grant held: throughput and latency.
        for (int i = 0; i < 10; i++)
            step(1'b1, tbl[i].f3, tbl[i].a, tbl[i].b, 6'(i + 8), 1'b1, 1'b0, tbl[i].exp);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // Four back-to-back MULs, grant low on cycles 3..5: stall then in-order drain.
        n = 0;
        for (int k = 0; k < 12; k++) begin
            g = !(k >= 3 && k <= 5);
            if (n < 4 && model_rdy(g)) begin
                a = 32'(n + 3); b = 32'hFFFF0000 + 32'(n);
                step(1'b1, MUL_F3, a, b, 6'(20 + n), g, 1'b0, ref_mul(MUL_F3, a, b));
                n++;
            end else idle(g);
        end

        // Flush with both stages valid and grant high: next cycle empty and ready.
        step(1'b1, MULHU_F3, 32'hDEADBEEF, 32'h12345678, 6'd30, 1'b1, 1'b0,
             ref_mul(MULHU_F3, 32'hDEADBEEF, 32'h12345678));
        step(1'b1, MULH_F3, 32'hCAFEF00D, 32'h87654321, 6'd31, 1'b1, 1'b0,
             ref_mul(MULH_F3, 32'hCAFEF00D, 32'h87654321));
        step(1'b1, MUL_F3, 32'h5, 32'h6, 6'd32, 1'b1, 1'b1, 32'h0);   // dropped
        idle(1'b1); idle(1'b1);

        // Reset while stalled with both stages full.
        step(1'b1, MUL_F3, 32'h11, 32'h22, 6'd40, 1'b0, 1'b0, 32'h242);
        step(1'b1, MUL_F3, 32'h33, 32'h44, 6'd41, 1'b0, 1'b0, 32'hD8C);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0; q.delete();
        chk_zero = 1; idle(1'b0); idle(1'b1); idle(1'b0); chk_zero = 0;

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            g  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 29) == 0);
            v  = ($urandom_range(0, 3) != 0) && model_rdy(g);
            f3 = ($urandom_range(0, 15) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h7FFFFFFF;
                1:       b = 32'h00000000;
                default: b = $urandom;
            endcase
            step(v, f3, a, b, 6'($urandom_range(0, 63)), g, fl, ref_mul(f3, a, b));
        end
        for (int k = 0; k < 4; k++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
